// File: rtl/t_ff_count_ctrl_if.sv
// Request/status bundle between count-request logic and the T-FF controller.
// master issues start/stop/dir/limit; slave reports bank state back.
interface t_ff_count_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             stop;
   logic             dir;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] t_vec;
   logic [WIDTH-1:0] q;
   logic             busy;
   logic             done;
   logic             sat;

   modport master (
      output start, stop, dir, limit,
      input  t_vec, q, busy, done, sat
   );

   modport slave (
      input  start, stop, dir, limit,
      output t_vec, q, busy, done, sat
   );
endinterface

// File: rtl/t_ff_count_ctrl.sv
// Sequencer stepping a WIDTH-bit T-FF bank up/down to a captured limit.
// Optional TFF_CTRL_SAT_EN: saturate at the ends instead of wrapping.
module t_ff_count_ctrl #(
   parameter int WIDTH = 4
) (
   input logic              clk,
   input logic              rst,
   t_ff_count_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           nxt;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] lim_r;
   logic [WIDTH-1:0] tog;
   logic [WIDTH-1:0] t_vec;
   logic             dir_r;
   logic             take;

`ifdef TFF_CTRL_SAT_EN
   logic sat_r;
   logic sat_set;
   logic at_end;

   assign at_end = dir_r ? (q == '0) : (q == '1);
`endif

   // Ripple of ones (up) or zeros (down) below each bit decides its toggle.
   always_comb begin
      tog    = '0;
      tog[0] = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         tog[i] = tog[i-1] & (q[i-1] ^ dir_r);
      end
   end

   always_comb begin
      nxt   = state;
      t_vec = '0;
      take  = 1'b0;
`ifdef TFF_CTRL_SAT_EN
      sat_set = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               take = 1'b1;
               nxt  = (q == bus.limit) ? DONE : RUN;
            end
         end
         RUN: begin
            if (bus.stop) begin
               nxt = IDLE;
            end
`ifdef TFF_CTRL_SAT_EN
            else if (at_end && (q != lim_r)) begin
               nxt     = DONE;
               sat_set = 1'b1;
            end
`endif
            else begin
               t_vec = tog;
               if ((q ^ tog) == lim_r) begin
                  nxt = DONE;
               end
            end
         end
         DONE: begin
            nxt = IDLE;
         end
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         q     <= '0;
         dir_r <= 1'b0;
         lim_r <= '0;
      end else begin
         state <= nxt;
         q     <= q ^ t_vec;
         if (take) begin
            dir_r <= bus.dir;
            lim_r <= bus.limit;
         end
      end
   end

`ifdef TFF_CTRL_SAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_r <= 1'b0;
      end else if (take) begin
         sat_r <= 1'b0;
      end else if (sat_set) begin
         sat_r <= 1'b1;
      end
   end

   assign bus.sat = sat_r;
`else
   assign bus.sat = 1'b0;
`endif

   assign bus.t_vec = t_vec;
   assign bus.q     = q;
   assign bus.busy  = (state != IDLE);
   assign bus.done  = (state == DONE);

endmodule

// File: tb/tb_t_ff_count_ctrl.sv
// Bench for t_ff_count_ctrl: directed vector tables, then random
// stimulus against a step-counting reference model.
module tb_t_ff_count_ctrl;

   localparam int W    = 4;
   localparam int MASK = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   t_ff_count_ctrl_if #(.WIDTH(W)) ifc ();

   t_ff_count_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   typedef struct {
      logic         rst;
      logic         start;
      logic         stop;
      logic         dir;
      logic [W-1:0] lim;
      bit           chk;
      logic [W-1:0] et;
      logic [W-1:0] eq;
      logic         eb;
      logic         ed;
      logic         es;
   } vec_t;

   vec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic add(int r, int s, int p, int d, int l, int c,
                      int et, int eq, int eb, int ed, int es);
      vec_t v;
      v.rst = r[0]; v.start = s[0]; v.stop = p[0]; v.dir = d[0];
      v.lim = l[W-1:0]; v.chk = (c != 0);
      v.et = et[W-1:0]; v.eq = eq[W-1:0];
      v.eb = eb[0]; v.ed = ed[0]; v.es = es[0];
      tbl.push_back(v);
   endtask

   task automatic drive(logic r, logic s, logic p, logic d, logic [W-1:0] l);
      rst       = r;
      ifc.start = s;
      ifc.stop  = p;
      ifc.dir   = d;
      ifc.limit = l;
   endtask

   task automatic run_table(string nm);
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].dir, tbl[i].lim);
         #1;
         if (tbl[i].chk) begin
            chk($sformatf("%s[%0d].t_vec", nm, i), ifc.t_vec, tbl[i].et);
            chk($sformatf("%s[%0d].q", nm, i), ifc.q, tbl[i].eq);
            chk($sformatf("%s[%0d].busy", nm, i), ifc.busy, tbl[i].eb);
            chk($sformatf("%s[%0d].done", nm, i), ifc.done, tbl[i].ed);
            chk($sformatf("%s[%0d].sat", nm, i), ifc.sat, tbl[i].es);
         end
         @(posedge clk);
         #1;
      end
      tbl.delete();
   endtask

   task automatic go(logic d, logic [W-1:0] l);
      int n;
      drive(1'b0, 1'b1, 1'b0, d, l);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
      n = 0;
      while (!ifc.done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("go.done", ifc.done, 1);
      chk("go.q", ifc.q, l);
      @(posedge clk);
      #1;
   endtask

   // reference model state
   int m_st, mq, mdir, mlim, msat;

   task automatic rand_phase(int cycles);
      int r, s, p, d, l;
      int n_st, n_q, n_dir, n_lim, n_sat, et, step;
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
      #1;
      m_st = 0; mq = 0; mdir = 0; mlim = 0; msat = 0;
      for (int c = 0; c < cycles; c++) begin
         r = ($urandom_range(0, 99) == 0) ? 1 : 0;
         s = ($urandom_range(0, 2) == 0) ? 1 : 0;
         p = ($urandom_range(0, 19) == 0) ? 1 : 0;
         d = $urandom_range(0, 1);
         l = $urandom_range(0, MASK);
         drive(r[0], s[0], p[0], d[0], l[W-1:0]);
         #1;
         step = mdir ? ((mq - 1) & MASK) : ((mq + 1) & MASK);
         n_st = m_st; n_q = mq; n_dir = mdir; n_lim = mlim; n_sat = msat;
         et = 0;
         if (m_st == 0) begin
            if (s) begin
               n_dir = d; n_lim = l; n_sat = 0;
               n_st = (mq == l) ? 2 : 1;
            end
         end else if (m_st == 1) begin
            if (p) begin
               n_st = 0;
            end
`ifdef TFF_CTRL_SAT_EN
            else if (((mdir == 0 && mq == MASK) || (mdir == 1 && mq == 0))
                     && mq != mlim) begin
               n_st = 2; n_sat = 1;
            end
`endif
            else begin
               et  = mq ^ step;
               n_q = step;
               if (step == mlim) n_st = 2;
            end
         end else begin
            n_st = 0;
         end
         chk("rnd.t_vec", ifc.t_vec, et);
         chk("rnd.q", ifc.q, mq);
         chk("rnd.busy", ifc.busy, (m_st != 0));
         chk("rnd.done", ifc.done, (m_st == 2));
         chk("rnd.sat", ifc.sat, msat);
         if (r) begin
            n_st = 0; n_q = 0; n_dir = 0; n_lim = 0; n_sat = 0;
         end
         m_st = n_st; mq = n_q; mdir = n_dir; mlim = n_lim; msat = n_sat;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("reset.q", ifc.q, 0);
      chk("reset.t_vec", ifc.t_vec, 0);
      chk("reset.busy", ifc.busy, 0);
      chk("reset.done", ifc.done, 0);
      chk("reset.sat", ifc.sat, 0);

      // up 0->5, then down 5->2
      add(0,1,0,0,5, 1, 0,0,0,0,0);
      add(0,0,0,0,0, 1, 1,0,1,0,0);
      add(0,0,0,0,0, 1, 3,1,1,0,0);
      add(0,0,0,0,0, 1, 1,2,1,0,0);
      add(0,0,0,0,0, 1, 7,3,1,0,0);
      add(0,0,0,0,0, 1, 1,4,1,0,0);
      add(0,0,0,0,0, 1, 0,5,1,1,0);
      add(0,1,0,1,2, 1, 0,5,0,0,0);
      add(0,0,0,0,0, 1, 1,5,1,0,0);
      add(0,0,0,0,0, 1, 7,4,1,0,0);
      add(0,0,0,0,0, 1, 1,3,1,0,0);
      add(0,0,0,0,0, 1, 0,2,1,1,0);
      add(0,0,0,0,0, 1, 0,2,0,0,0);
      run_table("updown");

      go(1'b0, 4'd14);

`ifdef TFF_CTRL_SAT_EN
      add(0,1,0,0,1,  1, 0,14,0,0,0);
      add(0,0,0,0,0,  1, 1,14,1,0,0);
      add(0,0,0,0,0,  1, 0,15,1,0,0);
      add(0,0,0,0,0,  1, 0,15,1,1,1);
      add(0,1,0,1,15, 1, 0,15,0,0,1);
      add(0,0,0,0,0,  1, 0,15,1,1,0);
      add(0,0,0,0,0,  1, 0,15,0,0,0);
`else
      add(0,1,0,0,1, 1, 0,14,0,0,0);
      add(0,0,0,0,0, 1, 1,14,1,0,0);
      add(0,0,0,0,0, 1, 15,15,1,0,0);
      add(0,0,0,0,0, 1, 1,0,1,0,0);
      add(0,0,0,0,0, 1, 0,1,1,1,0);
      add(0,0,0,0,0, 1, 0,1,0,0,0);
`endif
      add(1,0,0,0,0, 0, 0,0,0,0,0);
      run_table("wrap");

      // abort, ignored starts, zero distance, reset mid-run
      add(0,1,0,0,9, 1, 0,0,0,0,0);
      add(0,0,0,0,0, 1, 1,0,1,0,0);
      add(0,0,0,0,0, 1, 3,1,1,0,0);
      add(0,0,1,0,0, 1, 0,2,1,0,0);
      add(0,0,1,0,0, 1, 0,2,0,0,0);
      add(0,1,0,0,7, 1, 0,2,0,0,0);
      add(0,0,0,0,0, 1, 1,2,1,0,0);
      add(0,1,0,1,0, 1, 7,3,1,0,0);
      add(0,0,0,0,0, 1, 1,4,1,0,0);
      add(0,0,0,0,0, 1, 3,5,1,0,0);
      add(0,0,0,0,0, 1, 1,6,1,0,0);
      add(0,1,0,1,3, 1, 0,7,1,1,0);
      add(0,0,0,0,0, 1, 0,7,0,0,0);
      add(0,1,0,0,7, 1, 0,7,0,0,0);
      add(0,0,0,0,0, 1, 0,7,1,1,0);
      add(0,0,0,0,0, 1, 0,7,0,0,0);
      add(0,1,0,0,9, 1, 0,7,0,0,0);
      add(0,0,0,0,0, 1, 15,7,1,0,0);
      add(1,0,0,0,0, 1, 1,8,1,0,0);
      add(0,0,0,0,0, 1, 0,0,0,0,0);
      run_table("ctl");

      rand_phase(3000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
